// File: rtl/tnn_layer_sequencer.sv
// rtl/tnn_layer_sequencer.sv - two-layer TNN inference pass sequencer
// Latches a feature vector, steps both sparse layers through clear/run, and holds the class result.
module tnn_layer_sequencer #(
   parameter int FEAT_CNT   = 4,
   parameter int FEAT_BITS  = 4,
   parameter int HIDDEN_CNT = 4,
   parameter int CLASS_CNT  = 3,
   parameter int TIMEOUT    = 255
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [FEAT_CNT*FEAT_BITS-1:0] in_features,
   output logic [FEAT_CNT*FEAT_BITS-1:0] l1_features,
   output logic                          l1_rst,
   input  logic                          l1_done,
   input  logic [HIDDEN_CNT-1:0]         l1_out,
   output logic [HIDDEN_CNT-1:0]         l2_hidden,
   output logic                          l2_rst,
   input  logic                          l2_done,
   input  logic [CLASS_CNT-1:0]          l2_out,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CLASS_CNT-1:0]          out_class,
   output logic                          out_err,
   output logic                          busy
);

   localparam int FW   = FEAT_CNT * FEAT_BITS;
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_L1_CLR,
      S_L1_RUN,
      S_L2_CLR,
      S_L2_RUN,
      S_HOLD
   } state_e;

   state_e                state_q, state_d;
   logic [FW-1:0]         feat_q, feat_d;
   logic [HIDDEN_CNT-1:0] hid_q, hid_d;
   logic [CLASS_CNT-1:0]  cls_q, cls_d;
   logic                  err_q, err_d;
   logic [WD_W-1:0]       wd_q, wd_d, wd_inc;
   logic                  l1_rst_q, l2_rst_q;
   logic                  accept, wd_expired;

   assign in_ready   = (state_q == S_IDLE) | ((state_q == S_HOLD) & out_ready);
   assign accept     = in_valid & in_ready;
   // Watchdog saturates at TIMEOUT so a stuck layer can never wrap it back to a low count.
   assign wd_inc     = (wd_q == WD_MAX) ? WD_MAX : wd_q + WD_W'(1);
   assign wd_expired = (wd_inc == WD_MAX);

   always_comb begin
      state_d = state_q;
      feat_d  = feat_q;
      hid_d   = hid_q;
      cls_d   = cls_q;
      err_d   = err_q;
      wd_d    = wd_q;
      case (state_q)
         S_IDLE, S_HOLD: begin
            if (accept) begin
               feat_d  = in_features;
               state_d = S_L1_CLR;
            end else if (state_q == S_HOLD && out_ready) begin
               state_d = S_IDLE;
            end
         end
         S_L1_CLR: begin
            wd_d    = '0;
            state_d = S_L1_RUN;
         end
         S_L1_RUN: begin
            wd_d = wd_inc;
            if (l1_done) begin
               hid_d   = l1_out;
               state_d = S_L2_CLR;
            end else if (wd_expired) begin
               cls_d   = '0;
               err_d   = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_L2_CLR: begin
            wd_d    = '0;
            state_d = S_L2_RUN;
         end
         S_L2_RUN: begin
            wd_d = wd_inc;
            if (l2_done) begin
               cls_d   = l2_out;
               err_d   = 1'b0;
               state_d = S_HOLD;
            end else if (wd_expired) begin
               cls_d   = '0;
               err_d   = 1'b1;
               state_d = S_HOLD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         feat_q   <= '0;
         hid_q    <= '0;
         cls_q    <= '0;
         err_q    <= 1'b0;
         wd_q     <= '0;
         l1_rst_q <= 1'b0;
         l2_rst_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         feat_q   <= feat_d;
         hid_q    <= hid_d;
         cls_q    <= cls_d;
         err_q    <= err_d;
         wd_q     <= wd_d;
         l1_rst_q <= (state_d == S_L1_CLR);
         l2_rst_q <= (state_d == S_L2_CLR);
      end
   end

   // Layer clears are also held while rst_n is low so both datapaths start clean.
   assign l1_rst      = l1_rst_q | ~rst_n;
   assign l2_rst      = l2_rst_q | ~rst_n;
   assign l1_features = feat_q;
   assign l2_hidden   = hid_q;
   assign out_class   = cls_q;
   assign out_err     = err_q;
   assign out_valid   = (state_q == S_HOLD);
   assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/tnn_layer_sequencer.md
Name: tnn_layer_sequencer

Overview:
- Top-level controller for one TNN inference pass built on the direct (sparse) layer datapaths.
- Accepts a feature vector over a valid/ready handshake and latches it.
- Clears and runs the first layer, captures its hidden bits, then clears and runs the second layer.
- Presents the class-score bits with a valid/ready handshake. A watchdog aborts a pass if a layer never signals done.

Parameters:
FEAT_CNT, 4, number of input features (first-layer serial length)
FEAT_BITS, 4, bits per feature
HIDDEN_CNT, 4, first-layer neurons (second-layer serial length)
CLASS_CNT, 3, second-layer output bits
TIMEOUT, 255, maximum cycles allowed in a RUN state before abort; must be > max(FEAT_CNT, HIDDEN_CNT)

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  feature vector offered
in_ready  out  1  sequencer can accept a vector
in_features  in  FEAT_CNT*FEAT_BITS  feature vector
l1_features  out  FEAT_CNT*FEAT_BITS  latched vector driven to the first layer
l1_rst  out  1  active-high clear to the first layer
l1_done  in  1  first-layer done
l1_out  in  HIDDEN_CNT  first-layer hidden bits
l2_hidden  out  HIDDEN_CNT  latched hidden bits driven to the second layer
l2_rst  out  1  active-high clear to the second layer
l2_done  in  1  second-layer done
l2_out  in  CLASS_CNT  second-layer outputs
out_valid  out  1  result available
out_ready  in  1  consumer takes the result
out_class  out  CLASS_CNT  latched result
out_err  out  1  result was produced by a timeout abort
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, L1_CLR, L1_RUN, L2_CLR, L2_RUN, HOLD.
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - l1_features, l2_hidden, out_class, out_err and the watchdog counter clear to 0.
  - out_valid=0 and busy=0.
  - l1_rst and l2_rst are forced to 1 for as long as rst_n is low, so both layers are held clear.
  - A reset mid-pass discards the pass. No partial result is ever emitted.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). This is combinational.
- Acceptance happens on an edge where in_valid & in_ready: l1_features <= in_features, and the state goes to L1_CLR.
- l1_rst is registered. It is 1 exactly during the L1_CLR cycle and 0 otherwise. l2_rst follows the same rule for L2_CLR.
- L1_CLR goes to L1_RUN after one cycle. The watchdog clears on every RUN entry.
- L1_RUN:
  - Each cycle, watchdog += 1.
  - If l1_done=1: l2_hidden <= l1_out, then go to L2_CLR.
  - Else if the watchdog reaches TIMEOUT: go to HOLD with out_err <= 1 and out_class <= 0.
  - done takes priority over timeout on the same cycle.
- L2_CLR goes to L2_RUN after one cycle.
- L2_RUN behaves as L1_RUN, using l2_done. On done, out_class <= l2_out and out_err <= 0, then go to HOLD.
- HOLD:
  - out_valid=1; out_class and out_err stay stable until handshake.
  - If out_ready and in_valid: accept the new vector and go to L1_CLR directly (back-to-back, no IDLE bubble).
  - If out_ready without in_valid: go to IDLE.
- Latency:
  - With a layer whose done rises when its internal counter reaches N-1 after clear, L1_RUN lasts FEAT_CNT cycles and L2_RUN lasts HIDDEN_CNT cycles.
  - out_valid rises FEAT_CNT+HIDDEN_CNT+2 cycles after the acceptance edge.
- l1_done/l2_done are sampled only in their RUN states. Stale done levels in other states are ignored.
- The watchdog width is clog2(TIMEOUT+1) and it saturates; it never wraps.
- in_features changing after acceptance has no effect, because l1_features is held.

Test Plan:
1. Reset release, then in_valid with in_features=16'hA5C3, using layer models with FEAT_CNT=4 and HIDDEN_CNT=4 -> l1_rst pulses 1 cycle; l1_out=4'b1010 captured to l2_hidden; out_valid rises 10 cycles after acceptance; out_class equals l2_out=3'b011; out_err=0.
2. out_ready held low for 5 cycles in HOLD -> out_valid and out_class stay stable; in_ready=0; then out_ready=1 for 1 cycle -> IDLE and busy=0.
3. Back-to-back: in_valid held high with out_ready=1 -> second vector accepted on the HOLD exit edge; l1_rst re-pulses the next cycle; the second result arrives 10 cycles later.
4. l1_done tied low, TIMEOUT=20 -> HOLD entered 20 cycles into L1_RUN; out_err=1; out_class=0; l2_rst never pulsed.
5. rst_n asserted mid L2_RUN -> state is IDLE immediately; l1_rst=l2_rst=1 while low; out_valid stays 0; a subsequent pass gives a correct result.
6. l1_done held high before acceptance -> ignored in IDLE and L1_CLR; capture happens only on the L1_RUN done.
